clken_gen: RTL and testbench
============================

CLKEN_GEN -- requirements
Module: clken_gen

Interface
REQ-001 Parameter NCH, default 3: number of independent tick channels, range 1..8.
REQ-002 Parameter CW, default 32: divisor and counter width in bits.
REQ-003 Parameter DIV_INIT, default 49999999: divisor loaded into every channel at reset (1 Hz tick at 100 MHz when DIV=99999999; 2 Hz tick, 1 Hz sq at 49999999).
REQ-004 clk  input  1  master clock, 100 MHz.
REQ-005 clr  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  global run; low freezes all channels.
REQ-007 resync  input  1  phase-align restart of all channels.
REQ-008 cfg_wr  input  1  divisor write strobe, one cycle.
REQ-009 cfg_ch  input  3  target channel index.
REQ-010 cfg_div  input  CW  new divisor; tick period = cfg_div+1 clk cycles.
REQ-011 cfg_ack  output  1  one-cycle pulse, cycle after any cfg_wr.
REQ-012 cfg_err  output  1  one-cycle pulse with cfg_ack when cfg_ch >= NCH.
REQ-013 tick  output  NCH  per-channel one-cycle clock-enable pulse.
REQ-014 sq  output  NCH  per-channel square wave, toggles on each tick, period 2*(div+1).

Function
REQ-015 Each channel SHALL hold cnt (CW bits), div_act (active divisor) and div_pend (pending divisor).
REQ-016 Each edge with en=1, resync=0: if cnt==div_act then cnt<=0, tick<=1, sq<=~sq, div_act<=div_pend; else cnt<=cnt+1, tick<=0.
REQ-017 Each edge with en=0, resync=0: cnt, sq and div_act SHALL hold; tick<=0.
REQ-018 tick SHALL be registered; latency from wrap-condition edge to tick visible is exactly one cycle; tick never high two consecutive cycles unless div_act=0.
REQ-019 div_act=0 SHALL give tick high every cycle and sq toggling every cycle.
REQ-020 cnt arithmetic SHALL be CW-bit unsigned; cnt never exceeds div_act, so no wrap-around past 2^CW-1 occurs; divisor 2^CW-1 gives period 2^CW.
REQ-021 cfg_wr with cfg_ch<NCH SHALL load div_pend[cfg_ch]<=cfg_div; div_act changes only at the next wrap (glitch-free period change) or resync.
REQ-022 cfg_wr with cfg_ch>=NCH SHALL change no state; cfg_ack and cfg_err pulse next cycle.
REQ-023 cfg_wr on the same edge as that channel's wrap: wrap loads the old div_pend; new value applies at the following wrap.
REQ-024 resync=1 SHALL, regardless of en: cnt<=0, tick<=0, sq<=0, div_act<=div_pend, all channels simultaneously.
REQ-025 cfg_wr and resync on the same edge: write SHALL be forwarded, so that channel's div_act<=cfg_div.
REQ-026 Back-to-back cfg_wr each cycle SHALL be accepted; last write before a wrap wins.

Reset
REQ-027 clr=1 at an edge SHALL set cnt=0, div_act=div_pend=DIV_INIT, tick=0, sq=0, cfg_ack=0, cfg_err=0 for all channels; clr overrides resync, en, cfg_wr.
REQ-028 clr asserted mid-period SHALL discard pending writes; first tick after release follows REQ-016 from cnt=0.

Structure
REQ-029 Package clken_pkg SHALL hold CW default, DIV_INIT default, NCH maximum and channel-index width.
REQ-030 One sub-module clken_chan SHALL implement a single channel (REQ-015..021, 023-025); clken_gen instantiates NCH copies plus shared config decode and ack/err registers.

Verification
REQ-031 clr release, en=1, DIV_INIT=3 -> tick visible after edges 4,8,12; sq rises after edge 4, falls after edge 8.
REQ-032 ch1 div=9 running; cfg_wr ch1 div=4 at cnt=2 -> current period completes at 10 cycles, then 5-cycle periods.
REQ-033 en low for 7 cycles mid-period (div=3, cnt=1) -> no tick, sq held; resumes, next tick 3 active cycles later.
REQ-034 Channels div 2,4,6 free-running, pulse resync -> all cnt=0, sq=0; ticks after edges 3,5,7 post-resync; with cfg_wr same edge, new divisor used immediately.
REQ-035 cfg_wr cfg_ch=5 with NCH=3 -> cfg_ack=cfg_err=1 one cycle, all tick periods unchanged.
REQ-036 div=0 -> tick constant 1, sq toggling each cycle; clr mid-run -> all outputs 0 next cycle.

Source files
------------

// File: rtl/clken_pkg.sv
// rtl/clken_pkg.sv - shared widths and defaults for the tick-enable generator
package clken_pkg;

  // Default divisor/counter width in bits
  localparam int CW_DEF = 32;

  // Default divisor: 2 Hz tick and 1 Hz square wave from a 100 MHz clock
  localparam int DIV_INIT_DEF = 49999999;

  // Largest supported channel count and the width of a channel index
  localparam int NCH_MAX = 8;
  localparam int CH_W    = 3;

endpackage

// File: rtl/clken_chan.sv
// rtl/clken_chan.sv - one tick channel: counter, active/pending divisor, tick and square wave
module clken_chan
  import clken_pkg::*;
#(
  parameter int            CW       = CW_DEF,
  parameter logic [CW-1:0] DIV_INIT = CW'(DIV_INIT_DEF)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  input  logic          resync,
  input  logic          wr,
  input  logic [CW-1:0] wr_div,
  output logic          tick,
  output logic          sq
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] div_act_q, div_act_d;
  logic [CW-1:0] div_pend_q, div_pend_d;
  logic          tick_q, tick_d;
  logic          sq_q, sq_d;

  // Next-state: resync restarts the phase, otherwise count while enabled.
  // The wrap loads the pending divisor as it stood before this edge, so a
  // write landing on the wrap edge only takes effect one period later.
  always_comb begin
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = wr ? wr_div : div_pend_q;
    tick_d     = 1'b0;
    sq_d       = sq_q;
    if (resync) begin
      cnt_d     = '0;
      sq_d      = 1'b0;
      div_act_d = wr ? wr_div : div_pend_q;
    end else if (en) begin
      if (cnt_q == div_act_q) begin
        cnt_d     = '0;
        tick_d    = 1'b1;
        sq_d      = ~sq_q;
        div_act_d = div_pend_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers with synchronous clear back to the reset divisor
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q      <= '0;
      div_act_q  <= DIV_INIT;
      div_pend_q <= DIV_INIT;
      tick_q     <= 1'b0;
      sq_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      tick_q     <= tick_d;
      sq_q       <= sq_d;
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;

endmodule

// File: rtl/clken_gen.sv
// rtl/clken_gen.sv - multi-channel programmable clock-enable generator
module clken_gen
  import clken_pkg::*;
#(
  parameter int            NCH      = 3,
  parameter int            CW       = CW_DEF,
  parameter logic [CW-1:0] DIV_INIT = CW'(DIV_INIT_DEF)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            en,
  input  logic            resync,
  input  logic            cfg_wr,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [CW-1:0]   cfg_div,
  output logic            cfg_ack,
  output logic            cfg_err,
  output logic [NCH-1:0]  tick,
  output logic [NCH-1:0]  sq
);

  // Channel count widened by one bit so NCH_MAX itself is representable
  localparam logic [CH_W:0] NCH_L = (CH_W + 1)'(NCH);

  logic cfg_bad;
  logic cfg_ack_q, cfg_ack_d;
  logic cfg_err_q, cfg_err_d;

  assign cfg_bad = ({1'b0, cfg_ch} >= NCH_L);

  // Acknowledge every write; flag writes aimed at a channel that does not exist
  always_comb begin
    cfg_ack_d = cfg_wr;
    cfg_err_d = cfg_wr & cfg_bad;
  end

  // Ack/err pulse one cycle after the write strobe
  always_ff @(posedge clk) begin
    if (clr) begin
      cfg_ack_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_ack_q <= cfg_ack_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_ack = cfg_ack_q;
  assign cfg_err = cfg_err_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic ch_wr;
    assign ch_wr = cfg_wr & (cfg_ch == CH_W'(i));

    clken_chan #(
      .CW       (CW),
      .DIV_INIT (DIV_INIT)
    ) u_chan (
      .clk    (clk),
      .clr    (clr),
      .en     (en),
      .resync (resync),
      .wr     (ch_wr),
      .wr_div (cfg_div),
      .tick   (tick[i]),
      .sq     (sq[i])
    );
  end

endmodule

// File: tb/tb_clken_gen.sv
// tb/tb_clken_gen.sv - directed vector bench for clken_gen
module tb_clken_gen;

  logic       clk;
  logic       clr;
  logic       en;
  logic       resync;
  logic       cfg_wr;
  logic [2:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_ack;
  logic       cfg_err;
  logic [2:0] tick;
  logic [2:0] sq;

  int n_vec = 0;
  int n_err = 0;

  clken_gen #(
    .NCH      (3),
    .CW       (8),
    .DIV_INIT (8'd3)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .en      (en),
    .resync  (resync),
    .cfg_wr  (cfg_wr),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .cfg_ack (cfg_ack),
    .cfg_err (cfg_err),
    .tick    (tick),
    .sq      (sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       en;
    logic       resync;
    logic       wr;
    logic [2:0] ch;
    logic [7:0] div;
    logic [2:0] etick;
    logic [2:0] esq;
    logic       eack;
    logic       eerr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic c, input logic e, input logic r, input logic w,
                     input logic [2:0] ch, input logic [7:0] d,
                     input logic [2:0] et, input logic [2:0] es,
                     input logic ea, input logic ee);
    vec_t v;
    v.clr = c; v.en = e; v.resync = r; v.wr = w; v.ch = ch; v.div = d;
    v.etick = et; v.esq = es; v.eack = ea; v.eerr = ee;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Drive inputs after the active edge, then advance to just past the next one
  task automatic step(input logic c, input logic e, input logic r, input logic w,
                      input logic [2:0] ch, input logic [7:0] d);
    clr = c; en = e; resync = r; cfg_wr = w; cfg_ch = ch; cfg_div = d;
    @(posedge clk);
    #1;
  endtask

  int            divs[3];
  logic [2:0]    m_sq;
  logic [2:0]    m_tick;

  // Run k=1..n edges after a resync and compare against a period model
  task automatic run_model(input string nm, input int n);
    m_sq = 3'b000;
    for (int k = 1; k <= n; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
      for (int i = 0; i < 3; i++) m_tick[i] = ((k % (divs[i] + 1)) == 0);
      m_sq = m_sq ^ m_tick;
      chk($sformatf("%s_k%0d", nm, k), {10'd0, tick, sq}, {10'd0, m_tick, m_sq});
    end
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; resync = 1'b0; cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0;

    // Reset, startup with DIV_INIT=3, bad-channel write, ch0 divisor change
    add(1,0,0,0,3'd0,8'd0, 3'b000,3'b000,0,0);
    add(0,1,0,0,3'd0,8'd0, 3'b000,3'b000,0,0);
    add(0,1,0,0,3'd0,8'd0, 3'b000,3'b000,0,0);
    add(0,1,0,0,3'd0,8'd0, 3'b000,3'b000,0,0);
    add(0,1,0,0,3'd0,8'd0, 3'b111,3'b111,0,0);
    add(0,1,0,0,3'd0,8'd0, 3'b000,3'b111,0,0);
    add(0,1,0,0,3'd0,8'd0, 3'b000,3'b111,0,0);
    add(0,1,0,0,3'd0,8'd0, 3'b000,3'b111,0,0);
    add(0,1,0,0,3'd0,8'd0, 3'b111,3'b000,0,0);
    add(0,1,0,1,3'd5,8'd0, 3'b000,3'b000,1,1);
    add(0,1,0,0,3'd0,8'd0, 3'b000,3'b000,0,0);
    add(0,1,0,0,3'd0,8'd0, 3'b000,3'b000,0,0);
    add(0,1,0,0,3'd0,8'd0, 3'b111,3'b111,0,0);
    add(0,1,0,1,3'd0,8'd1, 3'b000,3'b111,1,0);
    add(0,1,0,0,3'd0,8'd0, 3'b000,3'b111,0,0);
    add(0,1,0,0,3'd0,8'd0, 3'b000,3'b111,0,0);
    add(0,1,0,0,3'd0,8'd0, 3'b111,3'b000,0,0);
    add(0,1,0,0,3'd0,8'd0, 3'b000,3'b000,0,0);
    add(0,1,0,0,3'd0,8'd0, 3'b001,3'b001,0,0);
    add(0,1,0,0,3'd0,8'd0, 3'b000,3'b001,0,0);
    add(0,1,0,0,3'd0,8'd0, 3'b111,3'b110,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].clr, tbl[i].en, tbl[i].resync, tbl[i].wr, tbl[i].ch, tbl[i].div);
      chk($sformatf("vec%0d", i), {8'd0, tick, sq, cfg_ack, cfg_err},
          {8'd0, tbl[i].etick, tbl[i].esq, tbl[i].eack, tbl[i].eerr});
    end

    // Mid-period divisor change on ch1: 10-cycle period completes, then 5-cycle
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 8'd9);
    chk("div_chg_resync", {14'd0, tick[1], sq[1]}, 16'd0);
    for (int k = 1; k <= 21; k++) begin
      logic et, es;
      step(1'b0, 1'b1, 1'b0, (k == 3), 3'd1, 8'd4);
      et = (k == 10) || (k == 15) || (k == 20);
      es = (k >= 10 && k < 15) || (k >= 20);
      chk($sformatf("div_chg_k%0d", k), {14'd0, tick[1], sq[1]}, {14'd0, et, es});
    end

    // Enable low for 7 cycles at cnt=1 freezes ch0; tick 3 active edges later
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
    for (int k = 1; k <= 11; k++) begin
      logic act_en;
      act_en = (k == 1) || (k >= 9);
      step(1'b0, act_en, 1'b0, 1'b0, 3'd0, 8'd0);
      chk($sformatf("freeze_k%0d", k), {14'd0, tick[0], sq[0]},
          {14'd0, (k == 11), (k == 11)});
    end

    // Resync with channels at 2,4,6; then resync with forwarded write on ch2
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'd2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 8'd4);
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 8'd6);
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
    chk("resync_clear", {10'd0, tick, sq}, 16'd0);
    divs[0] = 2; divs[1] = 4; divs[2] = 6;
    run_model("resync", 8);
    step(1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 8'd1);
    chk("resync_fwd_clear", {10'd0, tick, sq}, 16'd0);
    divs[2] = 1;
    run_model("resync_fwd", 8);

    // Divisor 0 on ch0: tick every cycle, sq toggling every cycle
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 8'd0);
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
      chk($sformatf("div0_k%0d", k), {14'd0, tick[0], sq[0]}, {14'd0, 1'b1, k[0]});
    end

    // Pending write discarded by clr; clr beats resync and cfg_wr
    step(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 8'd5);
    step(1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 8'd1);
    chk("clr_outputs", {8'd0, tick, sq, cfg_ack, cfg_err}, 16'd0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
      chk($sformatf("post_clr_k%0d", k), {13'd0, tick}, {13'd0, ((k % 4) == 0) ? 3'b111 : 3'b000});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
